// File: rtl/uc_pkg.sv
// Shared opcodes, state encoding and field helpers for the unid_controle_fsm control unit.
// State encoding is a 2-bit step with a separate halt bit on top.
package uc_pkg;

    localparam int OPC_W = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NAN = 3'b010;
    localparam logic [2:0] OP_MOV = 3'b011;
    localparam logic [2:0] OP_OUT = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_HLT = 3'b110;
    localparam logic [2:0] OP_REP = 3'b111;

    // {halt, step[1:0]}
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_T1     = 3'b001,
        ST_T2     = 3'b010,
        ST_T3     = 3'b011,
        ST_HALTED = 3'b100
    } uc_state_t;

    // Field offsets measured down from the instruction MSB.
    localparam int RX_OFS = OPC_W;

    function automatic int ry_ofs(input int rb);
        return OPC_W + rb;
    endfunction

    function automatic int sel_imm(input int nreg);
        return nreg;
    endfunction

    function automatic int sel_r(input int nreg);
        return nreg + 1;
    endfunction

endpackage

// File: rtl/uc_field_decode.sv
// Combinational split of the instruction register into opcode, RX, RY, onehot(RX), illegal.
// Under UC_HALT_EN opcode 110 is HLT, otherwise it is the only illegal opcode.
module uc_field_decode
    import uc_pkg::*;
#(
    parameter int NREG    = 8,
    parameter int INSTR_W = 16,
    localparam int RB     = $clog2(NREG)
) (
    input  logic [INSTR_W-1:0] ir,
    output logic [2:0]         opcode,
    output logic [RB-1:0]      rx,
    output logic [RB-1:0]      ry,
    output logic [NREG-1:0]    rx_onehot,
    output logic               illegal
);

    localparam int USED = OPC_W + 2 * RB;

    assign opcode    = ir[INSTR_W-1 -: OPC_W];
    assign rx        = ir[INSTR_W-1-RX_OFS -: RB];
    assign ry        = ir[INSTR_W-1-ry_ofs(RB) -: RB];
    assign rx_onehot = NREG'(1) << rx;

`ifdef UC_HALT_EN
    assign illegal = 1'b0;
`else
    assign illegal = (opcode == OP_HLT);
`endif

    // Low instruction bits carry no fields for this opcode map.
    if (INSTR_W > USED) begin : g_spare
        logic unused_low;
        assign unused_low = ^ir[INSTR_W-USED-1:0];
    end

endmodule

// File: rtl/unid_controle_fsm.sv
// Self-sequencing control unit: IDLE/T1/T2/T3 with zero-bubble issue from any final step.
// Optional UC_HALT_EN makes opcode 110 a HLT that parks in HALTED until reset.
module unid_controle_fsm
    import uc_pkg::*;
#(
    parameter int NREG    = 8,
    parameter int INSTR_W = 16,
    localparam int RB     = $clog2(NREG),
    localparam int SEL_W  = $clog2(NREG + 2)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic [INSTR_W-1:0] instrucao,
    output logic [2:0]         op_select,
    output logic [NREG-1:0]    reg_enable,
    output logic               a_enable,
    output logic               r_enable,
    output logic [SEL_W-1:0]   sel_reg,
    output logic               bus_enable,
    output logic               busy,
    output logic               done,
    output logic               illegal,
    output logic               halted
);

    uc_state_t          state, state_next;
    logic [INSTR_W-1:0] ir;
    logic               load_ir;
    logic               final_step;

    logic [2:0]      opcode;
    logic [RB-1:0]   rx, ry;
    logic [NREG-1:0] rx_onehot;
    logic            illegal_op;

    uc_field_decode #(.NREG(NREG), .INSTR_W(INSTR_W)) u_decode (
        .ir        (ir),
        .opcode    (opcode),
        .rx        (rx),
        .ry        (ry),
        .rx_onehot (rx_onehot),
        .illegal   (illegal_op)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (load_ir) ir <= instrucao;
        end
    end

    always_comb begin
        state_next = state;
        load_ir    = 1'b0;
        final_step = 1'b0;
        op_select  = '0;
        reg_enable = '0;
        a_enable   = 1'b0;
        r_enable   = 1'b0;
        sel_reg    = '0;
        bus_enable = 1'b0;
        done       = 1'b0;
        illegal    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (run) begin
                    load_ir    = 1'b1;
                    state_next = ST_T1;
                end
            end
            ST_T1: begin
                state_next = ST_T2;
                case (opcode)
                    OP_ADD, OP_SUB, OP_NAN: begin
                        sel_reg  = SEL_W'(rx);
                        a_enable = 1'b1;
                    end
                    OP_OUT:  sel_reg = SEL_W'(rx);
                    default: ;
                endcase
                if (illegal_op) begin
                    done       = 1'b1;
                    illegal    = 1'b1;
                    final_step = 1'b1;
                end
`ifdef UC_HALT_EN
                if (opcode == OP_HLT) state_next = ST_HALTED;
`endif
            end
            ST_T2: begin
                state_next = ST_T3;
                case (opcode)
                    OP_OUT: begin
                        sel_reg    = SEL_W'(rx);
                        bus_enable = 1'b1;
                        done       = 1'b1;
                        final_step = 1'b1;
                    end
                    OP_LDI: begin
                        sel_reg  = SEL_W'(sel_imm(NREG));
                        r_enable = 1'b1;
                    end
                    default: begin
                        sel_reg   = SEL_W'(ry);
                        op_select = opcode;
                        r_enable  = 1'b1;
                    end
                endcase
            end
            ST_T3: begin
                reg_enable = rx_onehot;
                sel_reg    = SEL_W'(sel_r(NREG));
                done       = 1'b1;
                final_step = 1'b1;
            end
            default: ;
        endcase

        // A final step doubles as an issue slot so back-to-back runs lose no cycle.
        if (final_step) begin
            if (run) begin
                load_ir    = 1'b1;
                state_next = ST_T1;
            end else begin
                state_next = ST_IDLE;
            end
        end
    end

    assign busy = (state == ST_T1) || (state == ST_T2) || (state == ST_T3);

`ifdef UC_HALT_EN
    assign halted = (state == ST_HALTED);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_unid_controle_fsm.sv
// Bench for unid_controle_fsm (NREG=8, INSTR_W=16): directed vector table, reset cases,
// then random run/instruction traffic checked against a per-instruction schedule model.
module tb_unid_controle_fsm;

`ifdef UC_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clock, reset, run;
    logic [15:0] instrucao;
    logic [2:0]  op_select;
    logic [7:0]  reg_enable;
    logic        a_enable, r_enable, bus_enable, busy, done, illegal, halted;
    logic [3:0]  sel_reg;
    logic [21:0] outs;

    int errors = 0;
    int checks = 0;
    logic [21:0] exp_q[$];

    unid_controle_fsm #(.NREG(8), .INSTR_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .instrucao  (instrucao),
        .op_select  (op_select),
        .reg_enable (reg_enable),
        .a_enable   (a_enable),
        .r_enable   (r_enable),
        .sel_reg    (sel_reg),
        .bus_enable (bus_enable),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal),
        .halted     (halted)
    );

    assign outs = {op_select, reg_enable, a_enable, r_enable, sel_reg,
                   bus_enable, busy, done, illegal, halted};

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [21:0] mk(int op, int regen, bit a, bit r, int sel,
                                       bit bus, bit bsy, bit dn, bit ill, bit hlt);
        logic [2:0] o3;
        logic [7:0] r8;
        logic [3:0] s4;
        o3 = op[2:0];
        r8 = regen[7:0];
        s4 = sel[3:0];
        return {o3, r8, a, r, s4, bus, bsy, dn, ill, hlt};
    endfunction

    task automatic check(string name, logic [21:0] act, logic [21:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (op,regen,a,r,sel,bus,busy,done,ill,halt)",
                     name, act, exp);
        end
    endtask

    // Reference model: current instruction plus how many of its cycles have elapsed.
    logic [15:0] m_ir;
    int          m_step;
    bit          m_halt;

    function automatic int lat(logic [15:0] i);
        int opc;
        opc = int'(i[15:13]);
        if (opc == 6) return HALT_EN ? 99 : 1;
        if (opc == 4) return 2;
        return 3;
    endfunction

    function automatic logic [21:0] expect_out();
        int opc, rx, ry;
        opc = int'(m_ir[15:13]);
        rx  = int'(m_ir[12:10]);
        ry  = int'(m_ir[9:7]);
        if (m_halt) return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        if (m_step == 0) return '0;
        if (m_step == 1) begin
            if (opc <= 2) return mk(0, 0, 1, 0, rx, 0, 1, 0, 0, 0);
            if (opc == 4) return mk(0, 0, 0, 0, rx, 0, 1, 0, 0, 0);
            if (opc == 6 && !HALT_EN) return mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
            return mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        end
        if (m_step == 2) begin
            if (opc == 4) return mk(0, 0, 0, 0, rx, 1, 1, 1, 0, 0);
            if (opc == 5) return mk(0, 0, 0, 1, 8, 0, 1, 0, 0, 0);
            return mk(opc, 0, 0, 1, ry, 0, 1, 0, 0, 0);
        end
        return mk(0, 1 << rx, 0, 0, 9, 0, 1, 1, 0, 0);
    endfunction

    task automatic model_clock(logic r, logic [15:0] i);
        if (m_halt) begin
            m_step = 0;
        end else if (m_step == 1 && HALT_EN && m_ir[15:13] == 3'b110) begin
            m_halt = 1'b1;
            m_step = 0;
        end else if (m_step == 0 || m_step == lat(m_ir)) begin
            if (r) begin
                m_ir   = i;
                m_step = 1;
            end else begin
                m_step = 0;
            end
        end else begin
            m_step++;
        end
    endtask

    typedef struct {
        logic        run;
        logic [15:0] instr;
        logic [21:0] exp;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int halt_cnt;
        reset     = 1'b1;
        run       = 1'b0;
        instrucao = '0;

        tbl[0]  = '{1'b1, 16'h0E80, mk(0, 0, 1, 0, 3, 0, 1, 0, 0, 0)};
        tbl[1]  = '{1'b0, 16'h0000, mk(0, 0, 0, 1, 5, 0, 1, 0, 0, 0)};
        tbl[2]  = '{1'b0, 16'h0000, mk(0, 8'h08, 0, 0, 9, 0, 1, 1, 0, 0)};
        tbl[3]  = '{1'b0, 16'h0000, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{1'b1, 16'h8800, mk(0, 0, 0, 0, 2, 0, 1, 0, 0, 0)};
        tbl[5]  = '{1'b0, 16'h0000, mk(0, 0, 0, 0, 2, 1, 1, 1, 0, 0)};
        tbl[6]  = '{1'b0, 16'h0000, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[7]  = '{1'b1, 16'hBC00, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
        tbl[8]  = '{1'b1, 16'hBC00, mk(0, 0, 0, 1, 8, 0, 1, 0, 0, 0)};
        tbl[9]  = '{1'b1, 16'hBC00, mk(0, 8'h80, 0, 0, 9, 0, 1, 1, 0, 0)};
        tbl[10] = '{1'b1, 16'h6700, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
        tbl[11] = '{1'b0, 16'h0000, mk(3, 0, 0, 1, 6, 0, 1, 0, 0, 0)};
        tbl[12] = '{1'b0, 16'h0000, mk(0, 8'h02, 0, 0, 9, 0, 1, 1, 0, 0)};
        tbl[13] = '{1'b0, 16'h0000, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
`ifdef UC_HALT_EN
        tbl[14] = '{1'b1, 16'hC000, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
        tbl[15] = '{1'b1, 16'h8800, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
        tbl[16] = '{1'b1, 16'h0E80, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
        tbl[17] = '{1'b0, 16'h0000, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
`else
        tbl[14] = '{1'b1, 16'hC000, mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0)};
        tbl[15] = '{1'b1, 16'h8800, mk(0, 0, 0, 0, 2, 0, 1, 0, 0, 0)};
        tbl[16] = '{1'b0, 16'h0000, mk(0, 0, 0, 0, 2, 1, 1, 1, 0, 0)};
        tbl[17] = '{1'b0, 16'h0000, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
`endif

        // reset, then abort an ADD in T2
        @(negedge clock);
        @(negedge clock);
        check("reset_outputs", outs, '0);
        reset = 1'b0;
        run = 1'b1;
        instrucao = 16'h0E80;
        @(negedge clock);
        run = 1'b0;
        @(negedge clock);
        check("add_t2_before_abort", outs, mk(0, 0, 0, 1, 5, 0, 1, 0, 0, 0));
        reset = 1'b1;
        #1;
        check("reset_mid_t2", outs, '0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle_after_abort", outs, '0);
        @(negedge clock);

        // directed table
        for (int i = 0; i < 18; i++) begin
            run       = tbl[i].run;
            instrucao = tbl[i].instr;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d", i), outs, tbl[i].exp);
            @(negedge clock);
        end

        run = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_after_table", outs, '0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle_after_table_reset", outs, '0);
        @(negedge clock);

        // random traffic against the schedule model
        m_ir = '0;
        m_step = 0;
        m_halt = 1'b0;
        halt_cnt = 0;
        exp_q.push_back(expect_out());
        for (int c = 0; c < 800; c++) begin
            check($sformatf("rand_c%0d", c), outs, exp_q.pop_front());
            if (m_halt) halt_cnt++;
            if (m_halt && halt_cnt > 3) begin
                run = 1'b0;
                reset = 1'b1;
                #1;
                check($sformatf("rand_reset_c%0d", c), outs, '0);
                #1;
                reset = 1'b0;
                m_halt = 1'b0;
                m_step = 0;
                halt_cnt = 0;
            end else begin
                run = ($urandom_range(0, 3) != 0);
                instrucao = 16'($urandom);
            end
            @(posedge clock);
            model_clock(run, instrucao);
            exp_q.push_back(expect_out());
            @(negedge clock);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
